// File: rtl/vend_pkg.sv
// Shared types and helpers for the coin arbiter that fronts a vending FSM.
// Provides: state_t {IDLE, OWN, RELEASE}, coin symbols NICKEL/DIME, idx_w().
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic NICKEL = 1'b0;
   localparam logic DIME   = 1'b1;

   // Requester index width; keeps at least one bit when n is 1.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Ports: req (requests), ptr (start index) -> onehot, idx, any.
import vend_pkg::*;

module vend_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IW-1:0]      idx,
   output logic               any
);

   always_comb begin
      logic [IW-1:0] j;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      j      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = IW'((int'(ptr) + k) % NUM_REQ);
         if (!any && req[j]) begin
            any       = 1'b1;
            idx       = j;
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vend_coin_arbiter.sv
// Locks one shared vending FSM to a single coin requester per transaction.
// Ports: CLK, RST; REQ/COIN in, GNT/ACK out; STEP/A to FSM, Y0/Y1 from FSM;
// VEND/CHANGE per-requester pulses; TIMEOUT/ERR release pulses; BUSY.
import vend_pkg::*;

module vend_coin_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 16,
   parameter int COIN_MAX    = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic [NUM_REQ-1:0] COIN,
   output logic [NUM_REQ-1:0] GNT,
   output logic [NUM_REQ-1:0] ACK,
   output logic               STEP,
   output logic               A,
   input  logic               Y0,
   input  logic               Y1,
   output logic [NUM_REQ-1:0] VEND,
   output logic [NUM_REQ-1:0] CHANGE,
   output logic               TIMEOUT,
   output logic               ERR,
   output logic               BUSY
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int CW = $clog2(COIN_MAX + 1);

   localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_CYC);
   localparam logic [CW-1:0] COIN_LIM = CW'(COIN_MAX);
   localparam logic [IW-1:0] LAST     = IW'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      own_q, own_d;
   logic [TW-1:0]      idle_q, idle_d, idle_inc;
   logic [CW-1:0]      coin_q, coin_d, coin_inc;
   logic [NUM_REQ-1:0] gnt_d, vend_d, chg_d;
   logic               to_d, err_d;
   logic [NUM_REQ-1:0] own_oh;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;

   vend_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req    (REQ),
      .ptr    (ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign own_oh   = NUM_REQ'(1) << own_q;
   // Saturating increments: counters never wrap back to zero.
   assign idle_inc = (idle_q == TO_LIM) ? idle_q : idle_q + 1'b1;
   assign coin_inc = (coin_q == COIN_LIM) ? coin_q : coin_q + 1'b1;
   assign BUSY     = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      gnt_d   = GNT;
      idle_d  = idle_q;
      coin_d  = coin_q;
      vend_d  = '0;
      chg_d   = '0;
      to_d    = 1'b0;
      err_d   = 1'b0;
      STEP    = 1'b0;
      A       = 1'b0;
      ACK     = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               own_d   = pick_idx;
               gnt_d   = pick_oh;
               state_d = OWN;
            end
         end
         OWN: begin
            STEP = REQ[own_q];
            A    = COIN[own_q];
            if (STEP) begin
               ACK    = own_oh;
               coin_d = coin_inc;
               idle_d = '0;
               chg_d  = Y0 ? own_oh : '0;
               vend_d = Y1 ? own_oh : '0;
               // A vend on the limit coin is a success, not an error.
               if (Y1) begin
                  gnt_d   = '0;
                  state_d = RELEASE;
               end else if (coin_inc == COIN_LIM) begin
                  err_d   = 1'b1;
                  gnt_d   = '0;
                  state_d = RELEASE;
               end
            end else begin
               idle_d = idle_inc;
               if (idle_inc == TO_LIM) begin
                  to_d    = 1'b1;
                  gnt_d   = '0;
                  state_d = RELEASE;
               end
            end
         end
         RELEASE: begin
            ptr_d   = (own_q == LAST) ? '0 : own_q + 1'b1;
            idle_d  = '0;
            coin_d  = '0;
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         idle_q  <= '0;
         coin_q  <= '0;
         GNT     <= '0;
         VEND    <= '0;
         CHANGE  <= '0;
         TIMEOUT <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         idle_q  <= idle_d;
         coin_q  <= coin_d;
         GNT     <= gnt_d;
         VEND    <= vend_d;
         CHANGE  <= chg_d;
         TIMEOUT <= to_d;
         ERR     <= err_d;
      end
   end

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Directed bench for vend_coin_arbiter (NUM_REQ=4, TIMEOUT_CYC=4, COIN_MAX=3).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_vend_coin_arbiter;

   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [N-1:0] REQ, COIN, GNT, ACK, VEND, CHANGE;
   logic         STEP, A, Y0, Y1, TIMEOUT, ERR, BUSY;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   vend_coin_arbiter #(
      .NUM_REQ     (N),
      .TIMEOUT_CYC (4),
      .COIN_MAX    (3)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .REQ     (REQ),
      .COIN    (COIN),
      .GNT     (GNT),
      .ACK     (ACK),
      .STEP    (STEP),
      .A       (A),
      .Y0      (Y0),
      .Y1      (Y1),
      .VEND    (VEND),
      .CHANGE  (CHANGE),
      .TIMEOUT (TIMEOUT),
      .ERR     (ERR),
      .BUSY    (BUSY)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Bounded wait for the next grant; an expired wait fails the grant check.
   task automatic wait_gnt();
      int n;
      n = 0;
      while (GNT == '0 && n < 6) begin
         nxt();
         settle();
         n++;
      end
   endtask

   // One whole transaction that vends on its first coin.
   task automatic grant_vend(input logic [N-1:0] exp);
      wait_gnt();
      chk("rr_gnt", GNT, exp);
      chk("rr_ack", ACK, exp);
      Y1 = 1'b1;
      nxt();
      Y1 = 1'b0;
      settle();
      chk("rr_vend", VEND, exp);
      chk("rr_gnt_clr", GNT, 0);
   endtask

   initial begin
      RST  = 1'b1;
      REQ  = 4'b1111;
      COIN = '0;
      Y0   = 1'b0;
      Y1   = 1'b0;

      // reset holds everything quiet even with all requests up
      repeat (2) begin
         nxt();
         settle();
         chk("rst_gnt", GNT, 0);
         chk("rst_step", STEP, 0);
         chk("rst_busy", BUSY, 0);
         chk("rst_pulse", {VEND, CHANGE, TIMEOUT, ERR}, 0);
      end

      // first grant from ptr=0 goes to requester 1
      RST = 1'b0;
      REQ = 4'b0110;
      settle();
      chk("idle_gnt", GNT, 0);
      chk("idle_ack", ACK, 0);
      nxt();
      COIN = 4'b0010;
      settle();
      chk("own1_gnt", GNT, 4'b0010);
      chk("own1_ack", ACK, 4'b0010);
      chk("own1_step", STEP, 1);
      chk("own1_a", A, 1);
      chk("own1_busy", BUSY, 1);
      nxt();
      Y0 = 1'b1;
      Y1 = 1'b1;
      settle();
      chk("step2_ack", ACK, 4'b0010);
      chk("step2_vend_early", VEND, 0);
      nxt();
      Y0 = 1'b0;
      Y1 = 1'b0;
      COIN = '0;
      settle();
      chk("vend_pulse", VEND, 4'b0010);
      chk("chg_pulse", CHANGE, 4'b0010);
      chk("rel_gnt", GNT, 0);
      chk("rel_ack", ACK, 0);
      chk("rel_busy", BUSY, 1);
      nxt();
      settle();
      chk("idle2_vend", VEND, 0);
      chk("idle2_busy", BUSY, 0);
      chk("idle2_gnt", GNT, 0);

      // requester 2 owns, then goes silent: timeout after 4 idle cycles
      nxt();
      REQ = 4'b0010;
      settle();
      chk("own2_gnt", GNT, 4'b0100);
      chk("own2_step", STEP, 0);
      chk("own2_ack", ACK, 0);
      for (int i = 2; i <= 4; i++) begin
         nxt();
         settle();
         chk("to_wait", TIMEOUT, 0);
         chk("to_hold_gnt", GNT, 4'b0100);
      end
      nxt();
      REQ = 4'b1010;
      settle();
      chk("to_pulse", TIMEOUT, 1);
      chk("to_gnt_clr", GNT, 0);
      nxt();
      settle();
      chk("to_pulse_end", TIMEOUT, 0);
      nxt();
      settle();
      chk("ptr_after_to", GNT, 4'b1000);

      // requester 3: three coins with no vend -> ERR
      chk("lim_step", STEP, 1);
      chk("lim_ack", ACK, 4'b1000);
      nxt();
      settle();
      chk("lim_err2", ERR, 0);
      nxt();
      settle();
      chk("lim_err3", ERR, 0);
      nxt();
      REQ = 4'b0001;
      settle();
      chk("err_pulse", ERR, 1);
      chk("err_vend", VEND, 0);
      chk("err_gnt", GNT, 0);
      nxt();
      settle();
      chk("err_end", ERR, 0);

      // requester 0: vend on the limit coin beats ERR
      nxt();
      settle();
      chk("lim0_gnt", GNT, 4'b0001);
      nxt();
      nxt();
      Y1 = 1'b1;
      settle();
      nxt();
      Y1 = 1'b0;
      settle();
      chk("lim_vend", VEND, 4'b0001);
      chk("lim_no_err", ERR, 0);

      // round robin with everyone requesting, from a fresh reset
      RST = 1'b1;
      REQ = 4'b1111;
      nxt();
      settle();
      chk("rst6_busy", BUSY, 0);
      chk("rst6_gnt", GNT, 0);
      RST = 1'b0;
      grant_vend(4'b0001);
      grant_vend(4'b0010);
      grant_vend(4'b0100);
      grant_vend(4'b1000);
      grant_vend(4'b0001);

      // reset in the middle of an ownership returns ptr to 0
      wait_gnt();
      chk("mid_gnt", GNT, 4'b0010);
      RST = 1'b1;
      nxt();
      settle();
      chk("midrst_gnt", GNT, 0);
      chk("midrst_busy", BUSY, 0);
      chk("midrst_step", STEP, 0);
      chk("midrst_pulse", {VEND, CHANGE}, 0);
      RST = 1'b0;
      nxt();
      settle();
      chk("midrst_ptr", GNT, 4'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
